// File: rtl/aemb2_pkg.sv
// Shared constants for the AEMB2 pipeline sequencer: FSM encoding and default timing.
package aemb2_pkg;

   localparam int unsigned STW      = 2;
   localparam int unsigned RSTC_DEF = 4;
   localparam int unsigned TMO_DEF  = 255;

   typedef enum logic [STW-1:0] {
      ST_RST  = 2'd0,
      ST_RUN  = 2'd1,
      ST_MULW = 2'd2
   } state_t;

endpackage

// File: rtl/aemb2_pipe_ctl.sv
// AEMB2 pipeline sequencer: global enable, thread phase, bus/multiply stalls,
// interrupt injection on phase 0 and a saturating bus-stall timeout.
module aemb2_pipe_ctl
   import aemb2_pkg::*;
#(
   parameter int unsigned TXE  = 1,
   parameter int unsigned MUL  = 0,
   parameter int unsigned RSTC = RSTC_DEF,
   parameter int unsigned TMO  = TMO_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       iwb_stb_i,
   input  logic       iwb_ack_i,
   input  logic       dwb_stb_i,
   input  logic       dwb_ack_i,
   input  logic       cwb_stb_i,
   input  logic       cwb_ack_i,
   input  logic       mul_req_i,
   input  logic       hte_i,
   input  logic       msr_ie_i,
   input  logic       int_i,
   output logic       ena_o,
   output logic       pha_o,
   output logic       int_take_o,
   output logic       bus_tmo_o,
   output logic [1:0] state_o
);

   state_t      stateQ, stateD;
   logic [2:0]  rstCntQ;
   logic [7:0]  stallCntQ;
   logic        phaQ;
   logic        pendQ;
   logic        mulDoneQ;
   logic        intQ;

   logic        bStall;
   logic        mStall;
   logic        ena;
   logic        intRise;
   logic        intTake;

   assign bStall = (iwb_stb_i & ~iwb_ack_i) | (dwb_stb_i & ~dwb_ack_i) |
                   (cwb_stb_i & ~cwb_ack_i);
   // mulDoneQ lets the instruction retire after its single bubble
   assign mStall = (MUL != 0) & mul_req_i & ~mulDoneQ;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stateQ <= ST_RST;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         ST_RST:  if (rstCntQ == 3'd1) stateD = ST_RUN;
         ST_RUN:  if (!bStall && mStall) stateD = ST_MULW;
         ST_MULW: stateD = ST_RUN;
         default: stateD = ST_RST;
      endcase
   end

   always_comb begin
      ena = 1'b0;
      unique case (stateQ)
         ST_RUN:  ena = ~bStall & ~mStall;
         default: ena = 1'b0;
      endcase
   end

   assign intRise = int_i & ~intQ;
   assign intTake = pendQ & msr_ie_i & ena & ~phaQ;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rstCntQ   <= 3'(RSTC);
         stallCntQ <= 8'd0;
         phaQ      <= 1'b0;
         pendQ     <= 1'b0;
         mulDoneQ  <= 1'b0;
         intQ      <= 1'b0;
      end else begin
         if (stateQ == ST_RST && rstCntQ != 3'd1) begin
            rstCntQ <= rstCntQ - 3'd1;
         end
         if (ena && (TXE != 0) && hte_i) begin
            phaQ <= ~phaQ;
         end
         intQ  <= int_i;
         // a fresh rising edge outranks the clear from a take in the same cycle
         pendQ <= intRise | (pendQ & ~intTake);
         if (stateQ == ST_MULW) begin
            mulDoneQ <= 1'b1;
         end else if (ena) begin
            mulDoneQ <= 1'b0;
         end
         if (stateQ == ST_RUN) begin
            if (!bStall) begin
               stallCntQ <= 8'd0;
            end else if (stallCntQ != 8'hff) begin
               stallCntQ <= stallCntQ + 8'd1;
            end
         end
      end
   end

   assign ena_o      = ena;
   assign pha_o      = phaQ;
   assign int_take_o = intTake;
   assign bus_tmo_o  = (stallCntQ >= 8'(TMO));
   assign state_o    = stateQ;

endmodule

// File: tb/tb_aemb2_pipe_ctl.sv
// Directed table-driven bench for aemb2_pipe_ctl (MUL=1/TMO=5 main instance plus a
// MUL=0/TXE=0/RSTC=1 companion instance sharing the same stimulus).
module tb_aemb2_pipe_ctl;

   logic       clk = 1'b0;
   logic       rst, iwbStb, iwbAck, dwbStb, dwbAck, cwbStb, cwbAck;
   logic       mulReq, hte, msrIe, intr;
   logic       ena, pha, take, tmo;
   logic [1:0] st;
   logic       ena0, pha0, take0, tmo0;
   logic [1:0] st0;

   always #5 clk = ~clk;

   aemb2_pipe_ctl #(.TXE(1), .MUL(1), .RSTC(4), .TMO(5)) dut (
      .clk_i(clk), .rst_i(rst),
      .iwb_stb_i(iwbStb), .iwb_ack_i(iwbAck),
      .dwb_stb_i(dwbStb), .dwb_ack_i(dwbAck),
      .cwb_stb_i(cwbStb), .cwb_ack_i(cwbAck),
      .mul_req_i(mulReq), .hte_i(hte), .msr_ie_i(msrIe), .int_i(intr),
      .ena_o(ena), .pha_o(pha), .int_take_o(take), .bus_tmo_o(tmo), .state_o(st)
   );

   aemb2_pipe_ctl #(.TXE(0), .MUL(0), .RSTC(1), .TMO(255)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .iwb_stb_i(iwbStb), .iwb_ack_i(iwbAck),
      .dwb_stb_i(dwbStb), .dwb_ack_i(dwbAck),
      .cwb_stb_i(cwbStb), .cwb_ack_i(cwbAck),
      .mul_req_i(mulReq), .hte_i(hte), .msr_ie_i(msrIe), .int_i(intr),
      .ena_o(ena0), .pha_o(pha0), .int_take_o(take0), .bus_tmo_o(tmo0), .state_o(st0)
   );

   // in  = {rst, istb,iack, dstb,dack, cstb,cack, mul, hte, ie, int}
   // exp = {ena, pha, take, tmo, state[1:0]}
   typedef struct {
      logic [10:0] in;
      logic [5:0]  exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input int n, input logic [10:0] in, input logic [5:0] exp);
      vec_t v;
      v.in  = in;
      v.exp = exp;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [10:0] in);
      {rst, iwbStb, iwbAck, dwbStb, dwbAck, cwbStb, cwbAck, mulReq, hte, msrIe, intr} = in;
   endtask

   initial begin
      int firstEna;
      int firstEna0;

      // reset and RSTC hold
      add(1, 11'b1_00_00_00_0_1_0_0, 6'b0_0_0_0_00);   // r0
      add(4, 11'b0_00_00_00_0_1_0_0, 6'b0_0_0_0_00);   // r1-4
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);   // r5
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_1_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      // data-bus stall for three cycles
      add(3, 11'b0_00_10_00_0_1_0_0, 6'b0_1_0_0_01);   // r8-10
      add(1, 11'b0_00_11_00_0_1_0_0, 6'b1_1_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      // interrupt rising edge with ie=1
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_1_0_0_01);   // r13
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_0_1_0_01);
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_1_0_0_01);
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_1_0_0_01);   // r17
      // interrupt with ie=0, then ie rises
      add(1, 11'b0_00_00_00_0_1_0_1, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_1, 6'b1_1_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_1, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_1_0_0_01);   // r21
      add(1, 11'b0_00_00_00_0_1_1_1, 6'b1_0_1_0_01);
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b1_1_0_0_01);
      // multiply held two cycles
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b0_0_0_0_01);   // r24
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b0_0_0_0_10);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_1_0_0_01);
      // multiply held three cycles: no second bubble
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b0_0_0_0_01);   // r28
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b0_0_0_0_10);
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_1_0_0_01);
      // bus stall has priority over multiply
      add(1, 11'b0_10_00_00_1_1_0_0, 6'b0_0_0_0_01);   // r32
      add(1, 11'b0_11_00_00_1_1_0_0, 6'b0_0_0_0_01);
      add(1, 11'b0_00_00_00_1_1_0_0, 6'b0_0_0_0_10);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      // instruction stall for eight cycles, TMO=5
      add(5, 11'b0_10_00_00_0_1_0_0, 6'b0_1_0_0_01);   // r36-40
      add(3, 11'b0_10_00_00_0_1_0_0, 6'b0_1_0_1_01);   // r41-43
      add(1, 11'b0_11_00_00_0_1_0_0, 6'b1_1_0_1_01);
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      // hte=0 holds the phase
      add(2, 11'b0_00_00_00_0_0_0_0, 6'b1_1_0_0_01);   // r46-47
      // FSL stall, then acks without strobes
      add(1, 11'b0_00_00_10_0_1_0_0, 6'b0_1_0_0_01);
      add(1, 11'b0_01_01_01_0_1_0_0, 6'b1_1_0_0_01);
      // reset with an interrupt pending
      add(1, 11'b0_00_00_00_0_1_0_1, 6'b1_0_0_0_01);   // r50
      add(1, 11'b0_00_00_00_0_1_0_0, 6'b1_1_0_0_01);
      add(1, 11'b1_00_00_00_0_1_0_0, 6'b1_0_0_0_01);
      add(4, 11'b0_00_00_00_0_1_1_0, 6'b0_0_0_0_00);   // r53-56
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b1_1_0_0_01);
      // reset during MULW
      add(1, 11'b0_00_00_00_1_1_1_0, 6'b0_0_0_0_01);   // r59
      add(1, 11'b1_00_00_00_1_1_1_0, 6'b0_0_0_0_10);
      add(4, 11'b0_00_00_00_0_1_1_0, 6'b0_0_0_0_00);   // r61-64
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b1_0_0_0_01);
      add(1, 11'b0_00_00_00_1_1_1_0, 6'b0_1_0_0_01);
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b0_1_0_0_10);
      add(1, 11'b0_00_00_00_0_1_1_0, 6'b1_1_0_0_01);   // r68

      drive(11'b1_00_00_00_0_1_0_0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].in);
         #2;
         check($sformatf("row%0d", i), {2'b00, ena, pha, take, tmo, st},
               {2'b00, vecs[i].exp});
         check($sformatf("row%0d_nomul", i), {5'd0, pha0, tmo0, st0 == 2'd2}, 8'd0);
         if (i == 24 || i == 28 || i == 59) begin
            check($sformatf("row%0d_nomul_ena", i), {7'd0, ena0}, 8'd1);
         end
      end

      // first enable after release: RSTC=4 on main, RSTC=1 on companion
      @(negedge clk);
      drive(11'b1_00_00_00_0_1_0_0);
      @(negedge clk);
      drive(11'b0_00_00_00_0_1_0_0);
      firstEna  = 99;
      firstEna0 = 99;
      for (int c = 0; c < 10; c++) begin
         #2;
         if (ena && firstEna == 99) firstEna = c;
         if (ena0 && firstEna0 == 99) firstEna0 = c;
         @(negedge clk);
      end
      check("release_rstc4", 8'(firstEna), 8'd4);
      check("release_rstc1", 8'(firstEna0), 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
